// File: rtl/mux_arbiter_pkg.sv
// Shared constants for the two-requester beat arbiter: FSM state encoding
// and the default burst limit.
package mux_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GRANT0 = 2'b01,
      GRANT1 = 2'b10
   } state_t;

   localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/mux_arbiter_mux2to14bit.sv
// Team 4-bit 2:1 data mux; sel=0 routes a, sel=1 routes b.
module mux2to14bit (
   input  logic       sel,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] y
);

   assign y = sel ? b : a;

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester burst arbiter feeding one registered 4-bit beat to a
// ready/valid consumer; fair alternation on ties, bounded burst length.
module mux_arbiter
   import mux_arbiter_pkg::*;
#(
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic [3:0] data0,
   input  logic       last0,
   input  logic       req1,
   input  logic [3:0] data1,
   input  logic       last1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       sel,
   output logic       out_valid,
   output logic [3:0] out_data,
   input  logic       out_ready
);

   localparam logic [2:0] BURST_LIM = 3'(MAX_BURST);

   state_t     state;
   logic [2:0] cnt;
   logic       ptr;
   logic [3:0] mux_data;
   logic       req_g;
   logic       last_g;
   logic       req_o;
   logic       acc;
   logic       burst_end;

   assign gnt0 = (state == GRANT0);
   assign gnt1 = (state == GRANT1);
   assign sel  = (state == GRANT1);

   mux2to14bit u_mux (
      .sel (sel),
      .a   (data0),
      .b   (data1),
      .y   (mux_data)
   );

   // Requester-relative views of the owner and the waiting side
   always_comb begin
      req_g     = sel ? req1 : req0;
      last_g    = sel ? last1 : last0;
      req_o     = sel ? req0 : req1;
      acc       = ((gnt0 & req0) | (gnt1 & req1)) & (~out_valid | out_ready);
      burst_end = (gnt0 | gnt1) &
                  ((acc & (last_g | ((cnt + 3'd1) == BURST_LIM))) | ~req_g);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         ptr       <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= 4'h0;
      end else begin
         if (acc) begin
            out_data  <= mux_data;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (req0 && req1)
                  state <= ptr ? GRANT0 : GRANT1;
               else if (req0)
                  state <= GRANT0;
               else if (req1)
                  state <= GRANT1;
            end
            GRANT0, GRANT1: begin
               if (burst_end) begin
                  cnt   <= 3'd0;
                  ptr   <= gnt1;
                  if (req_o)
                     state <= gnt0 ? GRANT1 : GRANT0;
                  else
                     state <= IDLE;
               end else if (acc) begin
                  cnt <= cnt + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_arbiter.sv
// Randomized bench for mux_arbiter against an owner/beat-count reference model.
module tb_mux_arbiter;

   localparam int MAXB = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0 = 1'b0, last0 = 1'b0, req1 = 1'b0, last1 = 1'b0;
   logic [3:0] data0 = 4'h0, data1 = 4'h0;
   logic       out_ready = 1'b0;
   logic       gnt0, gnt1, sel, out_valid;
   logic [3:0] out_data;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: who owns the path, beats taken this burst,
   // who was served last, and the beat sitting at the consumer.
   int         own      = -1;
   int         beats    = 0;
   int         last_srv = 1;
   bit         m_valid  = 1'b0;
   logic [3:0] m_data   = 4'h0;

   always #5 clk = ~clk;

   mux_arbiter #(.MAX_BURST(MAXB)) dut (
      .clk       (clk),
      .reset     (reset),
      .req0      (req0),
      .data0     (data0),
      .last0     (last0),
      .req1      (req1),
      .data1     (data1),
      .last1     (last1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_step();
      bit         r [2];
      bit         l [2];
      logic [3:0] d [2];
      bit         take;
      bit         done;
      r[0] = req0; r[1] = req1;
      l[0] = last0; l[1] = last1;
      d[0] = data0; d[1] = data1;
      if (reset) begin
         own = -1; beats = 0; last_srv = 1; m_valid = 1'b0; m_data = 4'h0;
         return;
      end
      take = (own >= 0) && r[own] && (!m_valid || out_ready);
      if (take) begin
         m_data  = d[own];
         m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      if (own < 0) begin
         if (r[0] && r[1]) own = 1 - last_srv;
         else if (r[0])    own = 0;
         else if (r[1])    own = 1;
      end else begin
         done = !r[own] || (take && (l[own] || (beats + 1 == MAXB)));
         if (done) begin
            last_srv = own;
            beats    = 0;
            own      = r[1 - own] ? 1 - own : -1;
         end else if (take) begin
            beats++;
         end
      end
   endtask

   task automatic compare_all();
      check_eq("gnt0", {7'd0, gnt0}, {7'd0, own == 0});
      check_eq("gnt1", {7'd0, gnt1}, {7'd0, own == 1});
      check_eq("sel", {7'd0, sel}, {7'd0, own == 1});
      check_eq("out_valid", {7'd0, out_valid}, {7'd0, m_valid});
      check_eq("out_data", {4'd0, out_data}, {4'd0, m_data});
   endtask

   task automatic apply(input bit r0, input logic [3:0] d0, input bit l0,
                        input bit r1, input logic [3:0] d1, input bit l1,
                        input bit rdy, input bit rst);
      @(negedge clk);
      compare_all();
      req0 = r0; data0 = d0; last0 = l0;
      req1 = r1; data1 = d1; last1 = l1;
      out_ready = rdy; reset = rst;
      model_step();
   endtask

   function automatic bit pct(input int p);
      return $urandom_range(0, 99) < p;
   endfunction

   task automatic rand_phase(input int cycles, input int p_r0, input int p_r1,
                             input int p_last, input int p_rdy, input int p_rst);
      for (int i = 0; i < cycles; i++)
         apply(pct(p_r0), 4'($urandom_range(0, 15)), pct(p_last),
               pct(p_r1), 4'($urandom_range(0, 15)), pct(p_last),
               pct(p_rdy), pct(p_rst));
   endtask

   initial begin
      // Reset state and the single-beat hand-off
      apply(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
      apply(1'b1, 4'hA, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      apply(1'b1, 4'hA, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      apply(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      apply(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);

      // Both requesting forever: max-length bursts alternating
      for (int i = 0; i < 24; i++)
         apply(1'b1, 4'(i), 1'b0, 1'b1, 4'(i + 8), 1'b0, 1'b1, 1'b0);

      // Backpressure held mid-burst, then released
      for (int i = 0; i < 3; i++)
         apply(1'b1, 4'h5, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++)
         apply(1'b1, 4'(i + 3), 1'b0, 1'b1, 4'(i + 9), 1'b0, 1'b1, 1'b0);

      // Reset while a beat is pending
      apply(1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      apply(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

      // Single requester with two-beat bursts
      for (int i = 0; i < 16; i++)
         apply(1'b1, 4'(i), (i % 2) == 1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

      rand_phase(40, 100, 100, 0, 100, 0);
      rand_phase(400, 80, 80, 15, 60, 0);
      rand_phase(300, 70, 70, 10, 30, 0);
      rand_phase(300, 85, 85, 20, 70, 2);
      rand_phase(100, 90, 0, 50, 80, 0);
      rand_phase(100, 0, 90, 5, 90, 0);

      @(negedge clk);
      compare_all();

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4; maximum accepted beats per grant before a forced switch; legal range 1..7.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 has a beat available on data0.
REQ-005 data0  input  4  requester 0 beat data.
REQ-006 last0  input  1  current requester 0 beat ends its burst.
REQ-007 req1  input  1  requester 1 has a beat available on data1.
REQ-008 data1  input  4  requester 1 beat data.
REQ-009 last1  input  1  current requester 1 beat ends its burst.
REQ-010 gnt0  output  1  requester 0 owns the shared 4-bit path.
REQ-011 gnt1  output  1  requester 1 owns the shared 4-bit path.
REQ-012 sel  output  1  mux select: 0 routes data0, 1 routes data1.
REQ-013 out_valid  output  1  out_data holds an unconsumed beat.
REQ-014 out_data  output  4  registered beat to consumer.
REQ-015 out_ready  input  1  consumer accepts out_data this cycle.

Function
REQ-016 States: IDLE, GRANT0, GRANT1, held in a state register.
REQ-017 gnt0 = (state==GRANT0); gnt1 = (state==GRANT1); sel = (state==GRANT1); all decoded from registered state only, never from req inputs.
REQ-018 Accept condition: acc = (gnt0&req0 | gnt1&req1) & (!out_valid | out_ready).
REQ-019 On acc: out_data <= selected data, out_valid <= 1, beat counter increments.
REQ-020 Without acc: out_valid clears when out_valid&out_ready, else holds; out_data holds.
REQ-021 Throughput: one beat per cycle sustained while granted requester holds req and out_ready=1.
REQ-022 IDLE: only req0 -> GRANT0; only req1 -> GRANT1; both -> requester not served last (priority pointer); neither -> IDLE.
REQ-023 Burst end in GRANTx: acc with lastx, or acc with counter reaching MAX_BURST, or reqx low while granted.
REQ-024 At burst end: next state GRANT of the other requester if its req is high, else IDLE; counter clears; pointer records x as last served.
REQ-025 Switch costs zero idle cycles: first beat of the new owner may be accepted the cycle after the last beat of the old owner.
REQ-026 Grant held while reqx high and out_ready low (backpressure); counter does not advance.
REQ-027 MAX_BURST=1: every accepted beat ends the burst; alternation when both request.
REQ-028 Counter is 3 bits; never exceeds MAX_BURST; no wrap.

Reset
REQ-029 reset=1 at a clock edge: state=IDLE, gnt0=gnt1=0, sel=0, out_valid=0, out_data=4'b0000, counter=0, pointer=requester 1 (so requester 0 wins first tie).
REQ-030 Reset mid-burst discards any pending out_data beat; no beat accepted in the reset cycle.
REQ-031 First grant possible in the cycle after reset deasserts.

Structure
REQ-032 State encodings (IDLE=2'b00, GRANT0=2'b01, GRANT1=2'b10) and MAX_BURST default in shared defines file; no other shared constants.
REQ-033 Data path instantiates the team's existing 4-bit 2:1 mux mux2to14bit driven by sel; arbitration FSM, counter and output register in mux_arbiter itself.

Verification
REQ-034 Reset then req0=1,data0=4'hA,last0=1,out_ready=1 -> gnt0=1 next cycle; out_valid=1,out_data=4'hA one cycle later; state back to IDLE.
REQ-035 Both req high from reset, last never asserted, MAX_BURST=4, out_ready=1 -> 4 beats from data0, then 4 from data1, alternating, no bubble at switches.
REQ-036 GRANT0 burst, out_ready=0 for 3 cycles -> out_data stable, out_valid=1, counter frozen, gnt0 held; resumes on out_ready=1 with no loss or duplicate.
REQ-037 req1 drops mid-burst in GRANT1 with req0=1 -> next cycle GRANT0, sel=0.
REQ-038 reset asserted mid-burst with out_valid=1 -> next cycle out_valid=0, gnt0=gnt1=0, out_data=4'h0.
REQ-039 Single req0 bursts of 2 beats (last0 on beat 2) repeated -> re-grant to 0 via IDLE each time; pointer ignored with one requester.
